// File: rtl/seq_alu.sv
// seq_alu: WIDTH-bit ALU with valid/ready handshakes on both sides and a
// multi-cycle shift-add unsigned multiplier. One operation in flight at a time.
// Optional build macro SEQ_ALU_EARLY_TERM_EN: the multiplier finishes as soon as
// the remaining multiplier bits are all zero.

module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;
  localparam logic [3:0] OpMul = 4'b1000;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]   result_q;
  logic               ovf_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               sub_op;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic               add_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               mul_last;

  assign accept = in_valid && (state_q == StIdle);

  // Single-cycle datapath: shared adder for ADD/SUB/SLT plus logic ops.
  always_comb begin
    sub_op  = (alu_ctl == OpSub) || (alu_ctl == OpSlt);
    b_eff   = sub_op ? ~b : b;
    sum     = a + b_eff + WIDTH'(sub_op);
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctl)
      OpAnd: alu_res = a & b;
      OpOr:  alu_res = a | b;
      OpNor: alu_res = ~(a | b);
      OpAdd, OpSub: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: ;
    endcase
  end

  // Multiplier step: conditional add of the shifted multiplicand; flags the final step.
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_ALU_EARLY_TERM_EN
    mul_last = (cnt_q == CntLast) || (mplier_q[WIDTH-1:1] == '0);
`else
    mul_last = (cnt_q == CntLast);
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE returns to IDLE only, so no accept on the handoff edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = (alu_ctl == OpMul) ? StMul : StDone;
      StMul:  if (mul_last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: handshakes decoded from state, flags from the registered result.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    result    = result_q;
    overflow  = ovf_q;
    zero      = (result_q == '0);
  end

  // Datapath registers: capture on accept, iterate in MUL, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      if (alu_ctl == OpMul) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= '0;
      end else begin
        result_q <= alu_res;
        ovf_q    <= alu_ovf;
      end
    end else if (state_q == StMul) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (mul_last) begin
        result_q <= acc_nxt[WIDTH-1:0];
        ovf_q    <= |acc_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Table-driven bench for seq_alu (WIDTH=32) plus back-pressure and reset sequences.

module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_ctl   (alu_ctl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        ovf;
    logic        zr;
    int          lat;   // 0 means multiply: latency from mul_lat()
  } vec_t;

  localparam int NVec = 16;
  vec_t vecs [NVec];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int mul_lat(input logic [31:0] mb);
`ifdef SEQ_ALU_EARLY_TERM_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) hi = i + 1;
    if (hi < 1) hi = 1;
    return hi + 1;
`else
    return 33;
`endif
  endfunction

  // Issue one op from a negedge, measure latency, sample outputs, then hand off.
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [3:0] tc, input logic [31:0] er, input logic eo,
                        input logic ez, input int el);
    int lat;
    check({name, ".in_ready"}, 64'(in_ready), 64'(1));
    a = ta; b = tb_; alu_ctl = tc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; alu_ctl = 4'b0010;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".lat"}, 64'(lat), 64'(el));
    check({name, ".result"}, 64'(result), 64'(er));
    check({name, ".overflow"}, 64'(overflow), 64'(eo));
    check({name, ".zero"}, 64'(zero), 64'(ez));
    check({name, ".busy"}, 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".released"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_ctl = '0;

    vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b1, 1'b0, 1};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0005, 4'b0110, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 32'h0000_0001, 1'b0, 1'b0, 1};
    vecs[3]  = '{32'h0000_0001, 32'hFFFF_FFFF, 4'b0111, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 4'b0111, 32'h0000_0001, 1'b0, 1'b0, 1};
    vecs[5]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0, 1'b0, 1};
    vecs[6]  = '{32'h0F0F_0000, 32'h0000_00F0, 4'b0001, 32'h0F0F_00F0, 1'b0, 1'b0, 1};
    vecs[7]  = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b1100, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[8]  = '{32'h8000_0000, 32'h0000_0001, 4'b0110, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
    vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[10] = '{32'h0000_FFFF, 32'h0000_00FF, 4'b0101, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[11] = '{32'h0001_0000, 32'h0001_0000, 4'b1000, 32'h0000_0000, 1'b1, 1'b1, 0};
    vecs[12] = '{32'h0000_0007, 32'h0000_0006, 4'b1000, 32'h0000_002A, 1'b0, 1'b0, 0};
    vecs[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 32'h0000_0001, 1'b1, 1'b0, 0};
    vecs[14] = '{32'h0001_2345, 32'h0000_0000, 4'b1000, 32'h0000_0000, 1'b0, 1'b1, 0};
    vecs[15] = '{32'h0000_FFFF, 32'h0001_0001, 4'b1000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0};

    repeat (2) @(negedge clk);
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check("reset.in_ready", 64'(in_ready), 64'(1));
    check("reset.result", 64'(result), 64'(0));
    check("reset.zero", 64'(zero), 64'(1));
    check("reset.overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVec; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].va, vecs[i].vb, vecs[i].ctl, vecs[i].res,
             vecs[i].ovf, vecs[i].zr, (vecs[i].lat == 0) ? mul_lat(vecs[i].vb) : vecs[i].lat);
    end

    // Back-pressure: result held 5 cycles, a pending request waits for IDLE.
    a = 32'd3; b = 32'd4; alu_ctl = 4'b0010; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd9; b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d.out_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'(0));
      check($sformatf("bp%0d.result", i), 64'(result), 64'(7));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.handoff.out_valid", 64'(out_valid), 64'(0));
    check("bp.handoff.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.next.out_valid", 64'(out_valid), 64'(1));
    check("bp.next.result", 64'(result), 64'(18));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset 10 cycles into a long multiply.
    a = 32'd7; b = 32'hFFFF_FFFF; alu_ctl = 4'b1000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rstmul.busy", 64'(out_valid), 64'(0));
    rst = 1'b1;
    #1;
    check("rstmul.out_valid", 64'(out_valid), 64'(0));
    check("rstmul.in_ready", 64'(in_ready), 64'(1));
    check("rstmul.result", 64'(result), 64'(0));
    check("rstmul.zero", 64'(zero), 64'(1));
    check("rstmul.overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post.mul", 32'd3, 32'd5, 4'b1000, 32'd15, 1'b0, 1'b0, mul_lat(32'd5));
    run_op("post.add", 32'd2, 32'd3, 4'b0010, 32'd5, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
